// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for load-use stalls, taken-branch flushes and HALT drain
//   clk, reset (async, active-low); read-stage operands rd_*; execute-stage status ex_*
//   stall_fetch/stall_read/bubble_execute, flush_fetch/flush_read, busy, halted
//   stall_cnt/flush_cnt saturating perf counters when PERF_CNT_EN is defined, else tied to 0
module hazard_ctrl #(
  parameter int LOAD_LAT = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_valid,
  input  logic [2:0]       rd_raddr_1,
  input  logic [2:0]       rd_raddr_2,
  input  logic             rd_uses_1,
  input  logic             rd_uses_2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [2:0]       ex_dest,
  input  logic             ex_branch_taken,
  input  logic             ex_halt,
  output logic             stall_fetch,
  output logic             stall_read,
  output logic             bubble_execute,
  output logic             flush_fetch,
  output logic             flush_read,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {RUN, LOAD_WAIT, HALT} state_t;
  localparam int WW = $clog2(LOAD_LAT + 1);
  localparam logic [WW-1:0] WAIT_INIT = WW'(LOAD_LAT > 1 ? LOAD_LAT - 2 : 0);
  state_t state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic luh;
  assign luh = rd_valid & ex_valid & ex_is_load &
               ((rd_uses_1 & (ex_dest == rd_raddr_1)) | (rd_uses_2 & (ex_dest == rd_raddr_2)));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  always_comb begin
    state_d = state_q;
    wait_d = wait_q;
    stall_fetch = 1'b0;
    stall_read = 1'b0;
    bubble_execute = 1'b0;
    flush_fetch = 1'b0;
    flush_read = 1'b0;
    busy = 1'b0;
    halted = 1'b0;
    if (state_q == HALT) begin
      {stall_fetch, stall_read, bubble_execute, busy, halted} = '1;
    end else if (state_q == LOAD_WAIT) begin
      {stall_fetch, stall_read, bubble_execute, busy} = '1;
      state_d = (wait_q == '0) ? RUN : LOAD_WAIT;
      wait_d = (wait_q == '0) ? wait_q : wait_q - WW'(1);
    end else if (ex_halt) begin
      {flush_fetch, flush_read} = '1;
      state_d = HALT;
    end else if (ex_branch_taken) begin
      {flush_fetch, flush_read} = '1;
    end else if (luh) begin
      {stall_fetch, stall_read, bubble_execute} = '1;
      // the luh cycle itself is the first of the LOAD_LAT stall cycles
      state_d = (LOAD_LAT > 1) ? LOAD_WAIT : RUN;
      wait_d = WAIT_INIT;
    end
    // outputs follow reset asynchronously, not just at the next edge
    if (!reset) {stall_fetch, stall_read, bubble_execute, flush_fetch, flush_read, busy, halted} = '0;
  end
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_read && state_q != HALT && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_read && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule
